// File: rtl/kwf_pkg.sv
// Shared types and constants for the keyword vote filter.
// Build option: define KWF_TIMEOUT_EN to enable the idle-gap timeout in TRACK.
package kwf_pkg;

    localparam int KW_WIDTH  = 4;
    localparam int SEQ_WIDTH = 8;
    localparam int RUN_WIDTH = 4;

    // Class code that means reject/silence unless the top overrides it
    localparam logic [KW_WIDTH-1:0] NONE_CLASS_DEFAULT = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        EMIT,
        REFRACT
    } state_t;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/kwf_down_counter.sv
// Loadable decrementing counter with a zero flag. Load has priority over
// decrement, and the count never wraps below zero.
module kwf_down_counter
    import kwf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load a new value or step down towards zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/keyword_vote_filter.sv
// Keyword vote filter: emits one event after CONFIRM_COUNT consecutive
// identical non-reject classifications, then discards REFRACTORY inputs.
// Build option: KWF_TIMEOUT_EN adds an idle-gap timeout that abandons a
// partial run after TIMEOUT_CYCLES clocks without an input handshake.
module keyword_vote_filter
    import kwf_pkg::*;
#(
    parameter int                  CONFIRM_COUNT  = 3,
    parameter int                  REFRACTORY     = 8,
    parameter logic [KW_WIDTH-1:0] NONE_CLASS     = NONE_CLASS_DEFAULT,
    parameter int                  TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [KW_WIDTH-1:0]  keyword_in,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [KW_WIDTH-1:0]  event_keyword,
    output logic [SEQ_WIDTH-1:0] event_seq
);

    localparam logic [RUN_WIDTH-1:0] CONFIRM_RUN = RUN_WIDTH'(CONFIRM_COUNT);
    localparam int                   REF_W       = cnt_width(REFRACTORY);
    localparam logic [REF_W-1:0]     REF_LOAD    = REF_W'(REFRACTORY);
    localparam logic [REF_W-1:0]     REF_LAST    = REF_W'(1);

    state_t               state;
    logic [KW_WIDTH-1:0]  cand;
    logic [RUN_WIDTH-1:0] run;

    logic in_hs;
    logic out_hs;
    logic is_reject;
    logic extends_run;
    logic confirm;
    logic timeout_hit;

    logic             ref_load;
    logic             ref_dec;
    logic [REF_W-1:0] ref_cnt;
    logic             unused_ref_zero;

    // Ready only depends on the registered state; it is forced low in reset
    assign din_ready   = rst && (state != EMIT);
    assign in_hs       = din_valid && din_ready;
    assign out_hs      = event_valid && event_ready;
    assign is_reject   = (keyword_in == NONE_CLASS);
    assign extends_run = (keyword_in == cand);
    assign confirm     = ((run + 4'd1) == CONFIRM_RUN);

    // Refractory window: loaded when the event is taken, stepped per discarded input
    assign ref_load = (state == EMIT) && out_hs;
    assign ref_dec  = (state == REFRACT) && in_hs;

    kwf_down_counter #(
        .WIDTH (REF_W)
    ) u_refract_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ref_load),
        .load_val (REF_LOAD),
        .dec      (ref_dec),
        .count    (ref_cnt),
        .zero     (unused_ref_zero)
    );

`ifdef KWF_TIMEOUT_EN
    localparam int               GAP_W     = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(1);

    logic             enter_track;
    logic             gap_load;
    logic [GAP_W-1:0] gap_val;
    logic             gap_dec;
    logic [GAP_W-1:0] gap_cnt;
    logic             unused_gap_zero;

    // A handshake that leaves the filter in TRACK restarts the gap window;
    // outside TRACK the counter is kept at zero.
    assign enter_track = in_hs && !is_reject &&
                         (((state == IDLE) && (CONFIRM_COUNT > 1)) ||
                          ((state == TRACK) && !(extends_run && confirm)));
    assign gap_load    = in_hs || (state != TRACK);
    assign gap_val     = enter_track ? GAP_LOAD : '0;
    assign gap_dec     = (state == TRACK) && !in_hs;
    assign timeout_hit = gap_dec && (gap_cnt == GAP_LAST);

    kwf_down_counter #(
        .WIDTH (GAP_W)
    ) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_val),
        .dec      (gap_dec),
        .count    (gap_cnt),
        .zero     (unused_gap_zero)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Vote FSM with registered event outputs and sequence number
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cand          <= '0;
            run           <= '0;
            event_valid   <= 1'b0;
            event_keyword <= '0;
            event_seq     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs && !is_reject) begin
                        cand <= keyword_in;
                        run  <= 4'd1;
                        if (CONFIRM_COUNT == 1) begin
                            state         <= EMIT;
                            event_valid   <= 1'b1;
                            event_keyword <= keyword_in;
                            run           <= '0;
                        end else begin
                            state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (in_hs) begin
                        if (is_reject) begin
                            state <= IDLE;
                            run   <= '0;
                        end else if (extends_run) begin
                            if (confirm) begin
                                state         <= EMIT;
                                event_valid   <= 1'b1;
                                event_keyword <= keyword_in;
                                run           <= '0;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end else begin
                            cand <= keyword_in;
                            run  <= 4'd1;
                        end
                    end else if (timeout_hit) begin
                        state <= IDLE;
                        run   <= '0;
                    end
                end
                EMIT: begin
                    if (event_ready) begin
                        event_valid <= 1'b0;
                        event_seq   <= event_seq + 8'd1;
                        state       <= (REFRACTORY == 0) ? IDLE : REFRACT;
                    end
                end
                REFRACT: begin
                    if (in_hs && (ref_cnt == REF_LAST)) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyword_vote_filter.sv
// Self-checking bench for keyword_vote_filter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// behavioural model of the vote/refractory rules.
module tb_keyword_vote_filter;

    localparam int CC   = 3;
    localparam int REF  = 8;
    localparam int TMO  = 64;
    localparam int NONE = 0;

    logic       clk;
    logic       rst;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] keyword_in;
    logic       event_valid;
    logic       event_ready;
    logic [3:0] event_keyword;
    logic [7:0] event_seq;

    keyword_vote_filter #(
        .CONFIRM_COUNT  (CC),
        .REFRACTORY     (REF),
        .NONE_CLASS     (4'd0),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .keyword_in    (keyword_in),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_keyword (event_keyword),
        .event_seq     (event_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending event, run length, refractory remaining
    bit m_pending;
    int m_seq, m_kw, m_cand, m_run, m_refr, m_gap;
    bit m_ihs, m_ohs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pending = 1'b0;
            m_seq = 0; m_kw = 0; m_cand = 0; m_run = 0; m_refr = 0; m_gap = 0;
        end else begin
            m_ihs = din_valid && !m_pending;
            m_ohs = m_pending && event_ready;
            if (m_ohs) begin
                m_pending = 1'b0;
                m_seq  = (m_seq + 1) % 256;
                m_refr = REF;
            end else if (m_ihs) begin
                if (m_refr > 0) begin
                    m_refr--;
                end else if (int'(keyword_in) == NONE) begin
                    m_run = 0;
                end else begin
                    if (m_run > 0 && int'(keyword_in) == m_cand) begin
                        m_run++;
                    end else begin
                        m_cand = int'(keyword_in);
                        m_run  = 1;
                    end
                    if (m_run == CC) begin
                        m_pending = 1'b1;
                        m_kw  = m_cand;
                        m_run = 0;
                    end
                end
            end
`ifdef KWF_TIMEOUT_EN
            if (m_ihs || m_run == 0) begin
                m_gap = 0;
            end else begin
                m_gap++;
                if (m_gap == TMO) begin
                    m_run = 0;
                    m_gap = 0;
                end
            end
`endif
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst && cmp_en) begin
            check("cyc_din_ready", int'(din_ready), int'(!m_pending));
            check("cyc_event_valid", int'(event_valid), int'(m_pending));
            check("cyc_event_seq", int'(event_seq), m_seq);
            if (m_pending) check("cyc_event_keyword", int'(event_keyword), m_kw);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int kw);
        din_valid  = 1'b1;
        keyword_in = 4'(kw);
        tick();
        din_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        din_valid = 1'b0;
        keyword_in = 4'd0;
        event_ready = 1'b1;
        tick();
        check("rst_din_ready_low", int'(din_ready), 0);
        check("rst_event_valid", int'(event_valid), 0);
        tick();
        rst = 1'b1;
        #1;
        check("rst_din_ready", int'(din_ready), 1);
        check("rst_event_keyword", int'(event_keyword), 0);
        check("rst_event_seq", int'(event_seq), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int k;
    int gap_left;

    initial begin
        rst = 1'b0;
        din_valid = 1'b0;
        keyword_in = 4'd0;
        event_ready = 1'b1;
        do_reset();
        cmp_en = 1'b1;

        // 5,5,5 back-to-back
        send(5); send(5);
        check("t1_valid_before_third", int'(event_valid), 0);
        send(5);
        check("t1_valid", int'(event_valid), 1);
        check("t1_keyword", int'(event_keyword), 5);
        check("t1_seq", int'(event_seq), 0);
        tick();
        check("t1_valid_after_hs", int'(event_valid), 0);
        check("t1_seq_after_hs", int'(event_seq), 1);

        // Reject class restarts the run
        do_reset();
        send(5); send(5); send(0); send(5); send(5);
        check("t2_valid_after_fifth", int'(event_valid), 0);
        send(5);
        check("t2_valid", int'(event_valid), 1);
        check("t2_keyword", int'(event_keyword), 5);
        check("t2_seq", int'(event_seq), 0);

        // Back-pressure, refractory discard, then a fresh event
        do_reset();
        event_ready = 1'b0;
        send(7); send(7); send(7);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_ready", int'(din_ready), 0);
            check("t3_hold_valid", int'(event_valid), 1);
            check("t3_hold_keyword", int'(event_keyword), 7);
        end
        event_ready = 1'b1;
        tick();
        check("t3_release_valid", int'(event_valid), 0);
        check("t3_release_seq", int'(event_seq), 1);
        for (int i = 0; i < 8; i++) begin
            send(7);
            check("t3_refract_valid", int'(event_valid), 0);
        end
        send(7); send(7);
        check("t3_partial_valid", int'(event_valid), 0);
        send(7);
        check("t3_second_valid", int'(event_valid), 1);
        check("t3_second_keyword", int'(event_keyword), 7);
        check("t3_second_seq", int'(event_seq), 1);
        tick();

        // 257 events: sequence number wraps
        do_reset();
        for (int i = 0; i < 257; i++) begin
            k = 1 + (i % 15);
            send(k); send(k); send(k);
            check("t4_valid", int'(event_valid), 1);
            check("t4_seq", int'(event_seq), i % 256);
            tick();
            for (int j = 0; j < 8; j++) send(0);
        end
        check("t4_seq_wrapped", int'(event_seq), 1);

        // Asynchronous reset while an event is pending
        do_reset();
        event_ready = 1'b0;
        send(2); send(2); send(2);
        check("t5_valid_before_rst", int'(event_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_valid", int'(event_valid), 0);
        check("t5_async_seq", int'(event_seq), 0);
        check("t5_async_ready", int'(din_ready), 0);
        check("t5_async_keyword", int'(event_keyword), 0);
        tick();
        rst = 1'b1;
        event_ready = 1'b1;
        #1;
        send(3); send(3); send(3);
        check("t5_after_valid", int'(event_valid), 1);
        check("t5_after_keyword", int'(event_keyword), 3);
        check("t5_after_seq", int'(event_seq), 0);
        tick();

        // 64-cycle gap inside a partial run
        do_reset();
        send(4); send(4);
        repeat (64) tick();
        send(4);
`ifdef KWF_TIMEOUT_EN
        check("t6_gap64_valid", int'(event_valid), 0);
`else
        check("t6_gap64_valid", int'(event_valid), 1);
        check("t6_gap64_keyword", int'(event_keyword), 4);
`endif
        tick();

        // 63-cycle gap always completes the run
        do_reset();
        send(4); send(4);
        repeat (63) tick();
        send(4);
        check("t6_gap63_valid", int'(event_valid), 1);
        check("t6_gap63_keyword", int'(event_keyword), 4);
        tick();

        // Randomized traffic checked every cycle by the compare process
        do_reset();
        k = 1;
        gap_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (gap_left > 0) begin
                gap_left--;
                din_valid = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                gap_left = int'($urandom_range(60, 70));
                din_valid = 1'b0;
            end else begin
                din_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) >= 6) k = int'($urandom_range(0, 3));
                keyword_in = 4'(k);
            end
            event_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        din_valid = 1'b0;
        event_ready = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
